sprite_renderer: RTL and testbench
==================================

SPRITE_RENDERER -- requirements
Module: sprite_renderer

Interface
REQ-001 SHALL have parameter SPR_W, default 36, meaning sprite width in texels.
REQ-002 SHALL have parameter SPR_H, default 36, meaning sprite height in texels.
REQ-003 SHALL have parameter SCALE_LOG2, default 1, meaning each texel is drawn as 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels.
REQ-004 SHALL have parameter FRAMES, default 4, meaning animation frames stored back-to-back in the ROM.
REQ-005 SHALL have parameter IDX_W, default 4, meaning palette index width.
REQ-006 SHALL have parameter TRANSP_IDX, default 0, meaning the palette index treated as transparent.
REQ-007 SHALL have parameter ANIM_DIV, default 8, meaning video frames per animation step.
REQ-008 Ports, clock and reset first: vga_clk in 1 pixel clock; Reset in 1 async active-high reset. One clock; reset is asynchronous and active-high.
REQ-009 Ports: DrawX in 10 pixel column; DrawY in 10 pixel row; blank in 1 high = active video.
REQ-010 Ports: upd_valid in 1 update offered; upd_ready out 1 update accepted this cycle when high with upd_valid; upd_x in 10 sprite left edge; upd_y in 10 sprite top edge; upd_flip in 1 horizontal mirror; upd_anim_en in 1 auto-animate.
REQ-011 Ports: rom_addr out ceil(log2(SPR_W*SPR_H*FRAMES)) ROM address; rom_q in IDX_W ROM data; pal_idx out IDX_W palette index; pal_rgb in 12 palette colour {r,g,b}, combinational from pal_idx.
REQ-012 Ports: red, green, blue out 4 each colour out; hit out 1 opaque sprite pixel present.

Function
REQ-013 Sprite box SHALL be pos_x <= DrawX < pos_x + SPR_W<<SCALE_LOG2, and likewise for Y; comparisons SHALL use 11-bit arithmetic, so a box extending past 639/479 clips and does not wrap.
REQ-014 Texel coordinates SHALL be tx = (DrawX-pos_x)>>SCALE_LOG2 and ty = (DrawY-pos_y)>>SCALE_LOG2; flip SHALL replace tx with SPR_W-1-tx.
REQ-015 rom_addr SHALL be frame*SPR_W*SPR_H + ty*SPR_W + tx, with no divider.
REQ-016 Pipeline: cycle 0 samples DrawX/DrawY/blank; rom_addr registered, valid cycle 1; external synchronous ROM returns rom_q cycle 2; red/green/blue/hit registered, valid cycle 3. Fixed latency 3.
REQ-017 In-box flag and blank SHALL be delayed alongside the address path.
REQ-018 At output stage: if delayed blank low, or not in-box, or rom_q==TRANSP_IDX, then rgb = 0 and hit = 0; otherwise rgb = pal_rgb and hit = 1.
REQ-019 Updates SHALL use a one-entry pending register; upd_ready = ~pending_full | apply.
REQ-020 Pending values SHALL be applied to the live pos_x/pos_y/flip/anim_en only at the vblank point (DrawX==0 && DrawY==480), so that no visible frame tears.
REQ-021 An accept and an apply in the same cycle SHALL apply the old pending entry and store the new one; pending_full stays 1.
REQ-022 Animation counter SHALL increment at each vblank point while anim_en, and on reaching ANIM_DIV-1 SHALL clear and advance frame, which wraps FRAMES-1 -> 0; anim_en=0 holds both.
REQ-023 Pipeline stages SHALL run every cycle regardless of update traffic.

Reset
REQ-024 Reset SHALL clear pos_x, pos_y, flip, anim_en, frame, anim counter, pending_full, and all pipeline registers asynchronously.
REQ-025 During reset and until the first valid pixel has propagated, red/green/blue/hit SHALL be 0, rom_addr 0, and upd_ready 1.
REQ-026 Reset mid-frame SHALL discard any pending update; output resumes 3 cycles after release.

Structure
REQ-027 A shared package SHALL hold H_ACTIVE=640, V_ACTIVE=480, the vblank-point constants, and the rgb12 struct typedef.
REQ-028 Sub-module sprite_anim_ctrl SHALL hold the pending register, apply logic and animation counter; the pixel pipeline SHALL be in the top module.

Verification
REQ-029 Static: upd (100,50, flip 0, anim 0), SCALE_LOG2=1; wait for vblank; pixel (100,50) -> hit, rom_addr 0 three cycles later; (171,50) -> rom_addr 35; (172,50) -> hit 0.
REQ-030 Flip: same position with flip=1; pixel (100,50) -> rom_addr 35.
REQ-031 Transparency/blank: rom_q = TRANSP_IDX -> rgb 0, hit 0; blank=0 inside the box -> rgb 0.
REQ-032 Clipping: pos (620,470); pixel (639,479) in-box, DrawX 0 -> hit 0 (no wrap).
REQ-033 Handshake: two updates back-to-back before vblank -> second stalls (upd_ready 0); update coincident with the vblank point -> first applied, second held; positions change only at DrawY=480.
REQ-034 Animation/reset: anim_en=1, ANIM_DIV=2, FRAMES=4 -> frame 0,0,1,1,2,2,3,3,0 over vblanks; assert Reset mid-line -> outputs 0 immediately, pending cleared.

Source files
------------

// File: rtl/sprite_renderer_pkg.sv
// sprite_renderer_pkg: shared video constants, colour and sprite-state types for the sprite renderer
package sprite_renderer_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int PIX_W    = $clog2(H_ACTIVE);

    localparam logic [PIX_W-1:0] VBLANK_X = '0;
    localparam logic [PIX_W-1:0] VBLANK_Y = PIX_W'(V_ACTIVE);

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    typedef struct packed {
        logic [PIX_W-1:0] x;
        logic [PIX_W-1:0] y;
        logic             flip;
        logic             anim_en;
    } sprite_cfg_t;

    function automatic logic at_vblank(input logic [PIX_W-1:0] x, input logic [PIX_W-1:0] y);
        return (x == VBLANK_X) && (y == VBLANK_Y);
    endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// sprite_anim_ctrl: one-entry update buffer applied at vblank, plus animation frame sequencing
module sprite_anim_ctrl
    import sprite_renderer_pkg::*;
#(
    parameter int FRAMES   = 4,
    parameter int ANIM_DIV = 8,
    parameter int FRAME_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIX_W-1:0]   draw_x,
    input  logic [PIX_W-1:0]   draw_y,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [PIX_W-1:0]   upd_x,
    input  logic [PIX_W-1:0]   upd_y,
    input  logic               upd_flip,
    input  logic               upd_anim_en,
    output logic [PIX_W-1:0]   pos_x,
    output logic [PIX_W-1:0]   pos_y,
    output logic               flip,
    output logic [FRAME_W-1:0] frame
);

    localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    sprite_cfg_t        pend_q, pend_d, live_q, live_d;
    logic               pend_full_q, pend_full_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               vblank, apply, accept, tick, wrap;

    always_comb begin
        vblank      = at_vblank(draw_x, draw_y);
        apply       = pend_full_q & vblank;
        upd_ready   = ~pend_full_q | apply;
        accept      = upd_valid & upd_ready;
        // the live copy takes the old pending entry even when a new one lands the same cycle
        pend_d      = accept ? {upd_x, upd_y, upd_flip, upd_anim_en} : pend_q;
        pend_full_d = accept | (pend_full_q & ~apply);
        live_d      = apply ? pend_q : live_q;
        tick        = vblank & live_q.anim_en;
        wrap        = cnt_q == CNT_W'(ANIM_DIV - 1);
        cnt_d       = tick ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
        frame_d     = (tick & wrap) ? ((frame_q == FRAME_W'(FRAMES - 1)) ? '0 : frame_q + 1'b1) : frame_q;
        pos_x       = live_q.x;
        pos_y       = live_q.y;
        flip        = live_q.flip;
        frame       = frame_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            live_q      <= '0;
            cnt_q       <= '0;
            frame_q     <= '0;
        end else begin
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            live_q      <= live_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
        end
    end

endmodule

// File: rtl/sprite_renderer.sv
// sprite_renderer: scaled, flippable, animated palette sprite overlay with a fixed 3-cycle pixel pipeline
module sprite_renderer
    import sprite_renderer_pkg::*;
#(
    parameter int SPR_W      = 36,
    parameter int SPR_H      = 36,
    parameter int SCALE_LOG2 = 1,
    parameter int FRAMES     = 4,
    parameter int IDX_W      = 4,
    parameter int TRANSP_IDX = 0,
    parameter int ANIM_DIV   = 8,
    localparam int ADDR_W    = $clog2(SPR_W * SPR_H * FRAMES)
) (
    input  logic              vga_clk,
    input  logic              Reset,
    input  logic [PIX_W-1:0]  DrawX,
    input  logic [PIX_W-1:0]  DrawY,
    input  logic              blank,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [PIX_W-1:0]  upd_x,
    input  logic [PIX_W-1:0]  upd_y,
    input  logic              upd_flip,
    input  logic              upd_anim_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_idx,
    input  rgb12_t            pal_rgb,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              hit
);

    localparam int          FRAME_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int          FRAME_SZ = SPR_W * SPR_H;
    localparam logic [10:0] BOX_W    = 11'(SPR_W << SCALE_LOG2);
    localparam logic [10:0] BOX_H    = 11'(SPR_H << SCALE_LOG2);

    logic [PIX_W-1:0]   pos_x, pos_y;
    logic               flip;
    logic [FRAME_W-1:0] frame;

    sprite_anim_ctrl #(
        .FRAMES   (FRAMES),
        .ANIM_DIV (ANIM_DIV),
        .FRAME_W  (FRAME_W)
    ) u_ctrl (
        .clk         (vga_clk),
        .rst         (Reset),
        .draw_x      (DrawX),
        .draw_y      (DrawY),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_x       (upd_x),
        .upd_y       (upd_y),
        .upd_flip    (upd_flip),
        .upd_anim_en (upd_anim_en),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .flip        (flip),
        .frame       (frame)
    );

    logic [10:0]       x_ext, y_ext, px, py, dx, dy, tx, ty, tx_f;
    logic              in_box, opaque;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              in_box1_q, in_box1_d, blank1_q, blank1_d;
    logic              in_box2_q, in_box2_d, blank2_q, blank2_d;
    rgb12_t            rgb_q, rgb_d;
    logic              hit_q, hit_d;

    always_comb begin
        // 11-bit compares let a box hanging off the right/bottom edge clip instead of wrapping
        x_ext     = {1'b0, DrawX};
        y_ext     = {1'b0, DrawY};
        px        = {1'b0, pos_x};
        py        = {1'b0, pos_y};
        in_box    = (x_ext >= px) && (x_ext < px + BOX_W) && (y_ext >= py) && (y_ext < py + BOX_H);
        dx        = x_ext - px;
        dy        = y_ext - py;
        tx        = dx >> SCALE_LOG2;
        ty        = dy >> SCALE_LOG2;
        tx_f      = flip ? 11'(SPR_W - 1) - tx : tx;
        addr_d    = in_box ? ADDR_W'(frame * FRAME_SZ + ty * SPR_W + tx_f) : '0;
        in_box1_d = in_box;
        blank1_d  = blank;
        in_box2_d = in_box1_q;
        blank2_d  = blank1_q;
        opaque    = blank2_q & in_box2_q & (rom_q != IDX_W'(TRANSP_IDX));
        rgb_d     = opaque ? pal_rgb : '0;
        hit_d     = opaque;
        rom_addr  = addr_q;
        pal_idx   = rom_q;
        red       = rgb_q.r;
        green     = rgb_q.g;
        blue      = rgb_q.b;
        hit       = hit_q;
    end

    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            addr_q    <= '0;
            in_box1_q <= 1'b0;
            blank1_q  <= 1'b0;
            in_box2_q <= 1'b0;
            blank2_q  <= 1'b0;
            rgb_q     <= '0;
            hit_q     <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            in_box1_q <= in_box1_d;
            blank1_q  <= blank1_d;
            in_box2_q <= in_box2_d;
            blank2_q  <= blank2_d;
            rgb_q     <= rgb_d;
            hit_q     <= hit_d;
        end
    end

endmodule

// File: tb/tb_sprite_renderer.sv
// tb_sprite_renderer: table-driven pixel vectors with a latency-tagged scoreboard for sprite_renderer
module tb_sprite_renderer;

    localparam int SW  = 36;
    localparam int SH  = 36;
    localparam int FR  = 4;
    localparam int FSZ = SW * SH;
    localparam int AW  = $clog2(SW * SH * FR);

    logic          vga_clk = 1'b0;
    logic          Reset = 1'b1;
    logic [9:0]    DrawX = '0, DrawY = '0;
    logic          blank = 1'b0;
    logic          upd_valid = 1'b0, upd_flip = 1'b0, upd_anim_en = 1'b0;
    logic [9:0]    upd_x = '0, upd_y = '0;
    logic          upd_ready;
    logic [AW-1:0] rom_addr;
    logic [3:0]    rom_q = '0, pal_idx;
    logic [11:0]   pal_rgb;
    logic [3:0]    red, green, blue;
    logic          hit;

    always #5 vga_clk = ~vga_clk;

    sprite_renderer #(
        .SPR_W(SW), .SPR_H(SH), .SCALE_LOG2(1), .FRAMES(FR),
        .IDX_W(4), .TRANSP_IDX(0), .ANIM_DIV(2)
    ) dut (
        .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_x(upd_x), .upd_y(upd_y),
        .upd_flip(upd_flip), .upd_anim_en(upd_anim_en), .rom_addr(rom_addr), .rom_q(rom_q),
        .pal_idx(pal_idx), .pal_rgb(pal_rgb), .red(red), .green(green), .blue(blue), .hit(hit)
    );

    // texel 37 is the only transparent one in this ROM image
    function automatic logic [3:0] rom_val(input int a);
        return (a == 37) ? 4'd0 : 4'((a % 15) + 1);
    endfunction

    function automatic logic [11:0] pal_f(input logic [3:0] i);
        return {i, ~i, i ^ 4'h5};
    endfunction

    assign pal_rgb = pal_f(pal_idx);
    always @(posedge vga_clk) rom_q <= rom_val(int'(rom_addr));

    typedef struct {
        int    due;
        int    val;
        string name;
    } exp_t;

    typedef struct {
        int    ph;
        int    x;
        int    y;
        bit    b;
        int    addr;
        bit    h;
        string nm;
    } vec_t;

    exp_t aq[$], oq[$];
    exp_t ea, eo;
    vec_t tbl[$];
    int   cyc = 0;
    int   total = 0, bad = 0;
    int   fr_seq[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

    always @(posedge vga_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge vga_clk) begin
        while (aq.size() > 0 && aq[0].due <= cyc) begin
            ea = aq.pop_front();
            if (ea.due < cyc) check({ea.name, " late"}, cyc, ea.due);
            else check(ea.name, int'(rom_addr), ea.val);
        end
        while (oq.size() > 0 && oq[0].due <= cyc) begin
            eo = oq.pop_front();
            if (eo.due < cyc) check({eo.name, " late"}, cyc, eo.due);
            else check(eo.name, int'({hit, red, green, blue}), eo.val);
        end
    end

    task automatic step(input int x, input int y, input bit b, input int addr, input bit h,
                        input bit chk, input int rdy, input string nm);
        exp_t e;
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        if (addr >= 0) begin
            e = '{cyc + 1, addr, {nm, " addr"}};
            aq.push_back(e);
        end
        if (chk) begin
            e = '{cyc + 3, h ? int'({1'b1, pal_f(rom_val(addr))}) : 0, {nm, " out"}};
            oq.push_back(e);
        end
        #1;
        if (rdy >= 0) check({nm, " rdy"}, int'(upd_ready), rdy);
        @(posedge vga_clk);
        #1;
    endtask

    task automatic vblank(input int rdy);
        step(0, 480, 1'b0, -1, 1'b0, 1'b1, rdy, "vblank");
    endtask

    task automatic set_upd(input int x, input int y, input bit f, input bit a);
        upd_x       = 10'(x);
        upd_y       = 10'(y);
        upd_flip    = f;
        upd_anim_en = a;
        upd_valid   = 1'b1;
    endtask

    task automatic run_ph(input int p);
        foreach (tbl[i])
            if (tbl[i].ph == p)
                step(tbl[i].x, tbl[i].y, tbl[i].b, tbl[i].addr, tbl[i].h, 1'b1, -1, tbl[i].nm);
    endtask

    initial begin
        tbl.push_back('{0, 100,  50, 1,    0, 1, "st_origin"});
        tbl.push_back('{0, 171,  50, 1,   35, 1, "st_right"});
        tbl.push_back('{0, 172,  50, 1,   -1, 0, "st_past_right"});
        tbl.push_back('{0,  99,  50, 1,   -1, 0, "st_left_out"});
        tbl.push_back('{0, 100,  49, 1,   -1, 0, "st_top_out"});
        tbl.push_back('{0, 102,  52, 1,   37, 0, "st_transp"});
        tbl.push_back('{0, 104,  54, 0,   74, 0, "st_blank"});
        tbl.push_back('{0, 171, 121, 1, 1295, 1, "st_corner"});
        tbl.push_back('{0, 171, 122, 1,   -1, 0, "st_below"});
        tbl.push_back('{0, 130,  60, 1,  195, 1, "st_mid"});
        tbl.push_back('{1, 100,  50, 1,   35, 1, "fl_origin"});
        tbl.push_back('{1, 171,  50, 1,    0, 1, "fl_right"});
        tbl.push_back('{1, 102,  52, 1,   70, 1, "fl_inner"});
        tbl.push_back('{2, 639, 479, 1,  153, 1, "cl_corner"});
        tbl.push_back('{2,   0, 479, 1,   -1, 0, "cl_nowrap_x"});
        tbl.push_back('{2, 639,   0, 1,   -1, 0, "cl_nowrap_y"});
        tbl.push_back('{2, 620, 470, 1,    0, 1, "cl_origin"});
        tbl.push_back('{2, 619, 470, 1,   -1, 0, "cl_left_out"});

        repeat (3) @(posedge vga_clk);
        #1;
        check("rst rgb", int'({red, green, blue}), 0);
        check("rst hit", int'(hit), 0);
        check("rst addr", int'(rom_addr), 0);
        check("rst rdy", int'(upd_ready), 1);
        Reset = 1'b0;

        set_upd(100, 50, 1'b0, 1'b0);
        step(100, 50, 1'b1, -1, 1'b0, 1'b1, 1, "st_req");
        upd_valid = 1'b0;
        vblank(-1);
        run_ph(0);

        set_upd(100, 50, 1'b1, 1'b0);
        step(5, 5, 1'b1, -1, 1'b0, 1'b1, 1, "fl_req");
        upd_valid = 1'b0;
        step(100, 50, 1'b1, 0, 1'b1, 1'b1, -1, "fl_not_yet");
        vblank(-1);
        run_ph(1);

        set_upd(620, 470, 1'b0, 1'b0);
        step(5, 5, 1'b1, -1, 1'b0, 1'b1, 1, "cl_req");
        upd_valid = 1'b0;
        vblank(-1);
        run_ph(2);

        set_upd(200, 100, 1'b0, 1'b0);
        step(5, 5, 1'b1, -1, 1'b0, 1'b1, 1, "hs_a");
        set_upd(300, 150, 1'b0, 1'b0);
        step(6, 5, 1'b1, -1, 1'b0, 1'b1, 0, "hs_b_stall");
        step(200, 100, 1'b1, -1, 1'b0, 1'b1, 0, "hs_a_pending");
        vblank(1);
        upd_valid = 1'b0;
        step(200, 100, 1'b1, 0, 1'b1, 1'b1, 0, "hs_a_live");
        step(300, 150, 1'b1, -1, 1'b0, 1'b1, 0, "hs_b_held");
        vblank(1);
        step(300, 150, 1'b1, 0, 1'b1, 1'b1, 1, "hs_b_live");
        step(200, 100, 1'b1, -1, 1'b0, 1'b1, 1, "hs_a_gone");

        set_upd(10, 10, 1'b0, 1'b1);
        step(5, 300, 1'b1, -1, 1'b0, 1'b1, 1, "an_req");
        upd_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            vblank(-1);
            step(10, 10, 1'b1, fr_seq[i] * FSZ, 1'b1, 1'b1, -1, $sformatf("an_frame%0d", i));
        end

        set_upd(400, 300, 1'b0, 1'b0);
        step(10, 10, 1'b1, -1, 1'b0, 1'b0, 1, "rs_req");
        upd_valid = 1'b0;
        step(10, 10, 1'b1, -1, 1'b0, 1'b0, -1, "rs_fill");
        #1;
        Reset = 1'b1;
        aq.delete();
        oq.delete();
        #1;
        check("rs rgb", int'({red, green, blue}), 0);
        check("rs hit", int'(hit), 0);
        check("rs addr", int'(rom_addr), 0);
        check("rs rdy", int'(upd_ready), 1);
        @(posedge vga_clk);
        @(posedge vga_clk);
        #1;
        check("rs hold hit", int'(hit), 0);
        Reset = 1'b0;
        step(0, 0, 1'b1, 0, 1'b1, 1'b1, 1, "rs_origin");
        vblank(-1);
        step(0, 0, 1'b1, 0, 1'b1, 1'b1, 1, "rs_vb_origin");
        step(400, 300, 1'b1, -1, 1'b0, 1'b1, 1, "rs_stale");

        repeat (4) step(5, 300, 1'b0, -1, 1'b0, 1'b0, -1, "drain");
        check("queue empty", aq.size() + oq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
